uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 8 +
 rtl/sync_2ff.sv | 15 +
 rtl/uart_rx.sv | 93 +++++++++
 tb/tb_uart_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and bit-timing helper
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_rx_state_t;
  function automatic int uart_cpb(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] s_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s_q <= {2{RST_VAL}};
    else s_q <= {s_q[0], d};
  assign q = s_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling and a one-entry valid/ready holding register
module uart_rx import uart_pkg::*; #(
  parameter int CLK_FREQ = 48_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int CPB = uart_cpb(CLK_FREQ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int TW = $clog2(CPB);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] HALF_T = TW'(HALF);
  localparam logic [TW-1:0] LAST_T = TW'(CPB - 1);
  localparam logic [IW-1:0] LAST_I = IW'(UART_DATA_BITS - 1);
  logic rx_s, commit, hold;
  uart_rx_state_t state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shf_q, shf_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk(clk_48mhz), .rst_n(reset_n), .d(rx_in), .q(rx_s)
  );
  always_comb begin
    state_d = state_q;
    tmr_d = (tmr_q == LAST_T) ? '0 : tmr_q + TW'(1);
    idx_d = idx_q;
    shf_d = shf_q;
    commit = 1'b0;
    ferr_d = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        tmr_d = '0;
      end
      START: if (tmr_q == HALF_T) begin
        state_d = rx_s ? IDLE : DATA;
        tmr_d = '0;
        idx_d = '0;
      end
      DATA: if (tmr_q == LAST_T) begin
        shf_d[idx_q] = rx_s;
        idx_d = idx_q + IW'(1);
        state_d = (idx_q == LAST_I) ? STOP : DATA;
      end
      STOP: if (tmr_q == LAST_T) begin
        state_d = rx_s ? IDLE : WAIT_IDLE;
        commit = rx_s;
        ferr_d = !rx_s;
      end
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a full register not drained this cycle keeps its byte; a new one is dropped
    hold = valid_q && !rx_ready;
    ovr_d = commit && hold;
    valid_d = commit || hold;
    data_d = (commit && !hold) ? shf_q : data_q;
  end
  always_ff @(posedge clk_48mhz or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      tmr_q <= '0;
      idx_q <= '0;
      shf_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      idx_q <= idx_d;
      shf_q <= shf_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
    end
  assign rx_data = data_q;
  assign rx_valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun = ovr_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven and randomized checks of uart_rx against a frame-level model
module tb_uart_rx;
  localparam int CPB = 52;
  localparam int HALF = 26;
  localparam int LAT = 2 + HALF + 9 * CPB + 1;
  typedef struct {
    logic [7:0] d;
    bit stop;
    int per;
    int exp_n;
    int exp_ferr;
  } vec_t;
  logic clk = 1'b0, reset_n = 1'b0, rx_in = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
  int total = 0, bad = 0;
  int n_ferr = 0, n_ovr = 0, n_vcyc = 0, n_stab = 0;
  logic [7:0] got_q[$];
  logic pv = 1'b0, ptake = 1'b0;
  logic [7:0] pd = 8'h00;
  vec_t tbl[6];
  uart_rx #(.CLK_FREQ(6_000_000), .BAUD(115200)) dut (
    .clk_48mhz(clk), .reset_n(reset_n), .rx_in(rx_in), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (reset_n) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) n_ferr <= n_ferr + 1;
      if (overrun) n_ovr <= n_ovr + 1;
      if (rx_valid) n_vcyc <= n_vcyc + 1;
      if (rx_valid && pv && !ptake && rx_data != pd) n_stab <= n_stab + 1;
      pv <= rx_valid;
      ptake <= rx_valid && rx_ready;
      pd <= rx_data;
    end else pv <= 1'b0;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input bit stop, input int per);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      tick(per);
    end
  endtask
  task automatic drain();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask
  initial begin
    int n, b0, f0, o0, v0, ef;
    logic [7:0] rd;
    bit rs;
    logic [7:0] exp_q[$];
    tick(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    tick(5);
    // latency from the first edge that sees the start bit low
    fork
      send_frame(8'hA5, 1'b1, CPB);
      begin
        n = 0;
        while (n < 2 * LAT) begin
          @(posedge clk);
          n++;
          #1;
          if (rx_valid) break;
        end
      end
    join
    chk("a5_latency", n - 1, LAT);
    chk("a5_data", rx_data, 8'hA5);
    tick(3 * CPB);
    chk("a5_held_valid", rx_valid, 1);
    chk("a5_held_data", rx_data, 8'hA5);
    b0 = got_q.size();
    drain();
    chk("a5_cleared", rx_valid, 0);
    chk("a5_taken", got_q.size() - b0, 1);
    tbl[0] = '{8'h00, 1'b1, CPB, 1, 0};
    tbl[1] = '{8'hFF, 1'b1, CPB - 1, 1, 0};
    tbl[2] = '{8'h5A, 1'b1, CPB + 1, 1, 0};
    tbl[3] = '{8'h81, 1'b0, CPB, 0, 1};
    tbl[4] = '{8'h01, 1'b1, CPB, 1, 0};
    tbl[5] = '{8'h80, 1'b0, CPB + 1, 0, 1};
    rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b0 = got_q.size();
      f0 = n_ferr;
      send_frame(tbl[i].d, tbl[i].stop, tbl[i].per);
      rx_in = 1'b1;
      tick(CPB);
      chk($sformatf("tbl%0d_count", i), got_q.size() - b0, tbl[i].exp_n);
      if (got_q.size() > b0) chk($sformatf("tbl%0d_data", i), got_q[b0], tbl[i].d);
      chk($sformatf("tbl%0d_ferr", i), n_ferr - f0, tbl[i].exp_ferr);
    end
    b0 = got_q.size();
    f0 = n_ferr;
    o0 = n_ovr;
    v0 = n_vcyc;
    send_frame(8'h00, 1'b1, CPB);
    send_frame(8'hFF, 1'b1, CPB);
    send_frame(8'h55, 1'b1, CPB);
    tick(CPB);
    chk("b2b_count", got_q.size() - b0, 3);
    chk("b2b_vcycles", n_vcyc - v0, 3);
    if (got_q.size() - b0 == 3) begin
      chk("b2b_0", got_q[b0], 8'h00);
      chk("b2b_1", got_q[b0 + 1], 8'hFF);
      chk("b2b_2", got_q[b0 + 2], 8'h55);
    end
    chk("b2b_errs", (n_ferr - f0) + (n_ovr - o0), 0);
    rx_ready = 1'b0;
    o0 = n_ovr;
    send_frame(8'h3C, 1'b1, CPB);
    send_frame(8'hC3, 1'b1, CPB);
    tick(CPB);
    chk("ovr_pulse", n_ovr - o0, 1);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h3C);
    b0 = got_q.size();
    drain();
    chk("ovr_drain", got_q.size() - b0, 1);
    if (got_q.size() > b0) chk("ovr_drain_data", got_q[b0], 8'h3C);
    // break condition: stop bit low, then line held low for 20 bit times
    f0 = n_ferr;
    send_frame(8'h81, 1'b0, CPB);
    tick(20 * CPB);
    chk("brk_ferr", n_ferr - f0, 1);
    chk("brk_valid", rx_valid, 0);
    chk("brk_busy", busy, 1);
    rx_in = 1'b1;
    tick(CPB);
    send_frame(8'h12, 1'b1, CPB);
    tick(CPB);
    chk("brk_next_valid", rx_valid, 1);
    chk("brk_next_data", rx_data, 8'h12);
    chk("brk_ferr_once", n_ferr - f0, 1);
    drain();
    f0 = n_ferr;
    rx_in = 1'b0;
    tick(10);
    rx_in = 1'b1;
    tick(HALF + 3 - 10);
    chk("glitch_busy_hi", busy, 1);
    tick(1);
    chk("glitch_busy_lo", busy, 0);
    tick(CPB);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_ferr", n_ferr - f0, 0);
    send_frame(8'h99, 1'b1, CPB);
    tick(CPB / 2);
    chk("rsthold_valid", rx_valid, 1);
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_in = ~rx_in;
      tick(CPB);
    end
    rx_in = 1'b1;
    tick(CPB / 2);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", rx_valid, 0);
    chk("midrst_data", rx_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pulses", {frame_err, overrun}, 0);
    tick(3);
    reset_n = 1'b1;
    tick(2 * CPB);
    chk("postrst_busy", busy, 0);
    rx_ready = 1'b1;
    b0 = got_q.size();
    send_frame(8'h7E, 1'b1, CPB);
    tick(CPB);
    chk("postrst_count", got_q.size() - b0, 1);
    if (got_q.size() > b0) chk("postrst_data", got_q[b0], 8'h7E);
    // randomized frames with up to about 2% baud error and occasional bad stop bits
    b0 = got_q.size();
    f0 = n_ferr;
    o0 = n_ovr;
    ef = 0;
    for (int i = 0; i < 24; i++) begin
      rd = 8'($urandom);
      rs = $urandom_range(0, 7) != 0;
      if (rs) exp_q.push_back(rd);
      else ef++;
      send_frame(rd, rs, $urandom_range(CPB - 1, CPB + 1));
      rx_in = 1'b1;
      tick(rs ? $urandom_range(0, CPB) : $urandom_range(CPB / 2, CPB));
    end
    tick(CPB);
    chk("rnd_count", got_q.size() - b0, exp_q.size());
    for (int k = 0; k < exp_q.size() && b0 + k < got_q.size(); k++)
      chk($sformatf("rnd_byte%0d", k), got_q[b0 + k], exp_q[k]);
    chk("rnd_ferr", n_ferr - f0, ef);
    chk("rnd_ovr", n_ovr - o0, 0);
    chk("data_stable", n_stab, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
